// File: rtl/gps_sweep_ctrl_if.sv
// Bus bundle between the register layer, the gps code generator and the result
// consumer. The master side is the environment; the slave side is the sequencer.
interface gps_sweep_ctrl_if #(
  parameter int NUM_SV = 8
);
  localparam int AW = $clog2(NUM_SV);

  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [5:0]    cfg_sv;
  logic          cfg_en;

  logic          sweep_start;
  logic          busy;
  logic          sweep_done;

  logic [5:0]    gen_sv_num;
  logic          gen_start;
  logic [12:0]   gen_ca_code;
  logic [127:0]  gen_py_code;
  logic          gen_py_valid;

  logic          res_valid;
  logic          res_ready;
  logic [AW-1:0] res_slot;
  logic [5:0]    res_sv;
  logic [12:0]   res_ca;
  logic [127:0]  res_py;
  logic          res_timeout;

  modport master (
    output cfg_we, cfg_addr, cfg_sv, cfg_en, sweep_start,
    output gen_ca_code, gen_py_code, gen_py_valid, res_ready,
    input  busy, sweep_done, gen_sv_num, gen_start,
    input  res_valid, res_slot, res_sv, res_ca, res_py, res_timeout
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_sv, cfg_en, sweep_start,
    input  gen_ca_code, gen_py_code, gen_py_valid, res_ready,
    output busy, sweep_done, gen_sv_num, gen_start,
    output res_valid, res_slot, res_sv, res_ca, res_py, res_timeout
  );
endinterface

// File: rtl/gps_sweep_ctrl.sv
// Constellation sweep sequencer: walks a table of SV numbers, launches the gps
// code generator for each enabled slot and presents the captured codes as results.
module gps_sweep_ctrl #(
  parameter int NUM_SV  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            rst,
  gps_sweep_ctrl_if.slave bus
);
  localparam int AW = $clog2(NUM_SV);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [AW-1:0] LAST_SLOT = AW'(NUM_SV - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, SCAN, LAUNCH, WAIT, EMIT, DONE} state_t;

  state_t          state, state_nxt;
  logic [NUM_SV-1:0] tbl_en;
  logic [5:0]      tbl_sv [NUM_SV];
  logic [AW-1:0]   ptr;
  logic [TW-1:0]   timer;
  logic            last_slot;
  logic            timer_exp;

  assign last_slot = (ptr == LAST_SLOT);
  assign timer_exp = (timer == LAST_TICK);

  assign bus.busy       = (state != IDLE);
  assign bus.sweep_done = (state == DONE);
  assign bus.gen_start  = (state == LAUNCH);
  assign bus.res_valid  = (state == EMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (bus.sweep_start) state_nxt = SCAN;
      SCAN: begin
        if (tbl_en[ptr])    state_nxt = LAUNCH;
        else if (last_slot) state_nxt = DONE;
      end
      LAUNCH: state_nxt = WAIT;
      WAIT:   if (bus.gen_py_valid || timer_exp) state_nxt = EMIT;
      EMIT:   if (bus.res_ready) state_nxt = last_slot ? DONE : SCAN;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Table writes are accepted in any state; SCAN only ever sees the registered copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tbl_en <= '0;
      tbl_sv <= '{default: '0};
    end else if (bus.cfg_we) begin
      tbl_en[bus.cfg_addr] <= bus.cfg_en;
      tbl_sv[bus.cfg_addr] <= bus.cfg_sv;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr             <= '0;
      timer           <= '0;
      bus.gen_sv_num  <= '0;
      bus.res_slot    <= '0;
      bus.res_sv      <= '0;
      bus.res_ca      <= '0;
      bus.res_py      <= '0;
      bus.res_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.sweep_start) ptr <= '0;
        SCAN: begin
          if (tbl_en[ptr])     bus.gen_sv_num <= tbl_sv[ptr];
          else if (!last_slot) ptr <= ptr + 1'b1;
        end
        LAUNCH: timer <= '0;
        WAIT: begin
          // Valid wins over timeout when both land on the final tick.
          if (bus.gen_py_valid) begin
            bus.res_ca      <= bus.gen_ca_code;
            bus.res_py      <= bus.gen_py_code;
            bus.res_timeout <= 1'b0;
            bus.res_slot    <= ptr;
            bus.res_sv      <= bus.gen_sv_num;
          end else if (timer_exp) begin
            bus.res_ca      <= bus.gen_ca_code;
            bus.res_py      <= '0;
            bus.res_timeout <= 1'b1;
            bus.res_slot    <= ptr;
            bus.res_sv      <= bus.gen_sv_num;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        EMIT: if (bus.res_ready && !last_slot) ptr <= ptr + 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_gps_sweep_ctrl.sv
// Randomized scoreboard bench for gps_sweep_ctrl with a behavioural gps responder
// and a slot-level timing model of the sweep.
`timescale 1ns/1ps
module tb_gps_sweep_ctrl;
  localparam int N  = 8;
  localparam int TO = 16;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gps_sweep_ctrl_if #(.NUM_SV(N)) bus();
  gps_sweep_ctrl #(.NUM_SV(N), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { int slot; logic [5:0] sv; } launch_t;
  typedef struct {
    int slot; logic [5:0] sv; logic [12:0] ca; logic [127:0] py; logic to; int rise;
  } res_t;

  launch_t exp_launch[$];
  res_t    exp_res[$];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_t = 0;
  int last_p = -1;
  int done_cnt = 0;
  int sweeps_issued = 0;
  bit ready_hold = 1'b0;
  logic       sh_en [N];
  logic [5:0] sh_sv [N];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // gps generator model: each launch answers after a random delay, possibly beyond the timeout.
  int job_active = 0, job_i = 0, job_d = 0, job_m = 0, spur = 0;
  logic [12:0]  job_ca;
  logic [127:0] job_py;
  launch_t cur_l;
  initial begin
    bus.gen_py_valid = 1'b0;
    bus.gen_ca_code  = '0;
    bus.gen_py_code  = '0;
    forever begin
      @(posedge clk); #1;
      bus.gen_py_valid = 1'b0;
      bus.gen_py_code  = {$urandom, $urandom, $urandom, $urandom};
      bus.gen_ca_code  = 13'($urandom);
      if (rst) begin
        job_active = 0;
        spur = 0;
      end else begin
        if (job_active != 0) begin
          job_i++;
          bus.gen_ca_code = job_ca;
          if (job_i == job_d) begin
            bus.gen_py_valid = 1'b1;
            bus.gen_py_code  = job_py;
          end
          if (job_i == job_m) begin
            job_active = 0;
            spur = 1;
          end
        end else if (spur != 0) begin
          spur = 0;
          bus.gen_py_valid = 1'b1;
        end
        if (bus.gen_start) begin
          if (exp_launch.size() == 0) begin
            check("unexpected gen_start", 128'(1), 128'(0));
          end else begin
            cur_l = exp_launch.pop_front();
            check("gen_sv_num", 128'(bus.gen_sv_num), 128'(cur_l.sv));
            check("launch cycle", 128'(cyc), 128'(last_t + 1 + (cur_l.slot - last_p)));
            job_d = $urandom_range(1, TO + 6);
            job_m = (job_d <= TO) ? job_d : TO;
            job_ca = 13'($urandom);
            job_py = {$urandom, $urandom, $urandom, $urandom};
            job_i = 0;
            job_active = 1;
            exp_res.push_back('{cur_l.slot, cur_l.sv, job_ca,
                                (job_d <= TO) ? job_py : 128'h0,
                                (job_d > TO), cyc + job_m + 1});
          end
        end
      end
    end
  end

  int stall = 0;
  initial begin
    bus.res_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (ready_hold) begin
        bus.res_ready = 1'b1;
      end else if (stall > 0) begin
        bus.res_ready = 1'b0;
        stall--;
      end else if ($urandom_range(0, 15) == 0) begin
        bus.res_ready = 1'b0;
        stall = 20;
      end else begin
        bus.res_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Result monitor.
  logic pv = 1'b0, pr = 1'b0, p_hs = 1'b0;
  logic [AW-1:0] p_slot;
  logic [5:0]    p_sv;
  logic [12:0]   p_ca;
  logic [127:0]  p_py;
  logic          p_to;
  res_t cur_r;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      pv = 1'b0; pr = 1'b0; p_hs = 1'b0;
    end else begin
      if (p_hs) check("res_valid after handshake", 128'(bus.res_valid), 128'(0));
      if (bus.res_valid && !pv) begin
        if (exp_res.size() == 0) begin
          check("unexpected res_valid", 128'(1), 128'(0));
        end else begin
          cur_r = exp_res[0];
          check("res_valid rise cycle", 128'(cyc), 128'(cur_r.rise));
          check("res_slot", 128'(bus.res_slot), 128'(cur_r.slot));
          check("res_sv", 128'(bus.res_sv), 128'(cur_r.sv));
          check("res_ca", 128'(bus.res_ca), 128'(cur_r.ca));
          check("res_py", bus.res_py, cur_r.py);
          check("res_timeout", 128'(bus.res_timeout), 128'(cur_r.to));
        end
      end
      if (bus.res_valid && pv && !pr) begin
        check("res hold fields", 128'({bus.res_slot, bus.res_sv, bus.res_ca, bus.res_timeout}),
              128'({p_slot, p_sv, p_ca, p_to}));
        check("res hold py", bus.res_py, p_py);
      end
      if (bus.gen_start && bus.res_valid) check("gen_start during result", 128'(1), 128'(0));
      p_hs = bus.res_valid && bus.res_ready;
      if (p_hs) begin
        if (exp_res.size() > 0) exp_res.delete(0);
        last_t = cyc;
        last_p = int'(bus.res_slot);
      end
      if (bus.sweep_done) begin
        done_cnt++;
        check("sweep_done cycle", 128'(cyc), 128'(last_t + N - last_p));
      end
      pv = bus.res_valid; pr = bus.res_ready;
      p_slot = bus.res_slot; p_sv = bus.res_sv; p_ca = bus.res_ca;
      p_py = bus.res_py; p_to = bus.res_timeout;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cfg_write(input int a, input logic en, input logic [5:0] sv);
    bus.cfg_we = 1'b1; bus.cfg_addr = a[AW-1:0]; bus.cfg_en = en; bus.cfg_sv = sv;
    tick();
    bus.cfg_we = 1'b0;
    sh_en[a] = en; sh_sv[a] = sv;
  endtask

  task automatic clear_table();
    for (int i = 0; i < N; i++) cfg_write(i, 1'b0, 6'd0);
  endtask

  task automatic run_sweep(input bit extra);
    bit seen;
    for (int i = 0; i < N; i++) if (sh_en[i]) exp_launch.push_back('{i, sh_sv[i]});
    last_t = cyc; last_p = -1; sweeps_issued++;
    bus.sweep_start = 1'b1;
    tick();
    bus.sweep_start = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 3000 && !seen; t++) begin
      if (bus.sweep_done) seen = 1'b1;
      bus.sweep_start = extra && ($urandom_range(0, 7) == 0);
      tick();
    end
    bus.sweep_start = 1'b0;
    if (!seen) check("sweep_done wait bound", 128'(0), 128'(1));
    check("idle after sweep", 128'(bus.busy), 128'(0));
  endtask

  task automatic empty_sweep();
    int s;
    s = cyc; last_t = s; last_p = -1; sweeps_issued++;
    bus.sweep_start = 1'b1;
    tick();
    bus.sweep_start = 1'b0;
    for (int c = s + 1; c <= s + N + 3; c++) begin
      check("empty busy", 128'(bus.busy), 128'(c <= s + N + 1));
      check("empty sweep_done", 128'(bus.sweep_done), 128'(c == s + N + 1));
      check("empty gen_start", 128'(bus.gen_start), 128'(0));
      bus.sweep_start = (c == s + 4) || (c == s + N + 1);
      tick();
    end
    bus.sweep_start = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " busy"}, 128'(bus.busy), 128'(0));
    check({tag, " sweep_done"}, 128'(bus.sweep_done), 128'(0));
    check({tag, " gen_start"}, 128'(bus.gen_start), 128'(0));
    check({tag, " gen_sv_num"}, 128'(bus.gen_sv_num), 128'(0));
    check({tag, " res_valid"}, 128'(bus.res_valid), 128'(0));
    check({tag, " res_slot/sv/ca/to"},
          128'({bus.res_slot, bus.res_sv, bus.res_ca, bus.res_timeout}), 128'(0));
    check({tag, " res_py"}, bus.res_py, 128'(0));
  endtask

  initial begin
    bit got_start;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_sv = '0; bus.cfg_en = 1'b0;
    bus.sweep_start = 1'b0;
    for (int i = 0; i < N; i++) begin sh_en[i] = 1'b0; sh_sv[i] = '0; end
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    tick();

    // Single enabled slot.
    clear_table();
    cfg_write(0, 1'b1, 6'd12);
    run_sweep(1'b0);

    // Sparse slots with the consumer always ready.
    clear_table();
    cfg_write(1, 1'b1, 6'd5);
    cfg_write(3, 1'b1, 6'd17);
    cfg_write(6, 1'b1, 6'd31);
    ready_hold = 1'b1;
    run_sweep(1'b0);
    ready_hold = 1'b0;

    clear_table();
    empty_sweep();

    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < N; i++) cfg_write(i, 1'($urandom_range(0, 1)), 6'($urandom));
      run_sweep(1'b1);
    end

    // Reset while the generator is being waited on.
    clear_table();
    cfg_write(2, 1'b1, 6'd40);
    exp_launch.push_back('{2, 6'd40});
    last_t = cyc; last_p = -1;
    bus.sweep_start = 1'b1;
    tick();
    bus.sweep_start = 1'b0;
    got_start = 1'b0;
    for (int t = 0; t < 50 && !got_start; t++) begin
      if (bus.gen_start) got_start = 1'b1;
      else tick();
    end
    check("launch before reset", 128'(got_start), 128'(1));
    tick();
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check_outputs_zero("async reset");
    exp_res.delete();
    exp_launch.delete();
    for (int i = 0; i < N; i++) begin sh_en[i] = 1'b0; sh_sv[i] = '0; end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    tick();
    empty_sweep();

    repeat (5) tick();
    check("launches outstanding", 128'(exp_launch.size()), 128'(0));
    check("results outstanding", 128'(exp_res.size()), 128'(0));
    check("sweep_done count", 128'(done_cnt), 128'(sweeps_issued));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
